decode_stage: RTL and testbench

//  Consumes fetch->decode packets (pc + 32-bit insn word) and emits one registered

---
 rtl/decode_pkg.sv | 36 +++
 rtl/decode_fields.sv | 23 ++
 rtl/decode_stage.sv | 148 ++++++++++++++
 tb/tb_decode_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage: FSM states, decoded-op record,
// instruction field positions and immediate sign-extension helper.
package decode_pkg;

  localparam int unsigned ADDR_W = 64;

  localparam logic [7:0] DEF_MAX_OPCODE = 8'h3F;
  localparam logic [7:0] LOADI64_OPCODE = 8'h3F;

  localparam int unsigned OPCODE_LSB = 24;
  localparam int unsigned RD_LSB     = 19;
  localparam int unsigned RS1_LSB    = 14;
  localparam int unsigned RS2_LSB    = 9;
  localparam int unsigned IMM_W      = 14;

  typedef enum logic [1:0] {
    StDecode,
    StImmLo,
    StImmHi
  } decode_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [7:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [63:0]       imm;
    logic              illegal;
  } DecodedOp;

  function automatic logic [63:0] sext_imm14(logic [IMM_W-1:0] v);
    return {{(64 - IMM_W){v[IMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Pure combinational slicing of one instruction word into a decoded-op record.
module decode_fields
  import decode_pkg::*;
#(
  parameter logic [7:0] MAX_OPCODE = DEF_MAX_OPCODE
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       insn,
  output DecodedOp          op
);

  always_comb begin
    op         = '0;
    op.pc      = pc;
    op.opcode  = insn[OPCODE_LSB +: 8];
    op.rd      = insn[RD_LSB +: 5];
    op.rs1     = insn[RS1_LSB +: 5];
    op.rs2     = insn[RS2_LSB +: 5];
    op.imm     = sext_imm14(insn[IMM_W-1:0]);
    op.illegal = (insn[OPCODE_LSB +: 8] > MAX_OPCODE);
  end

endmodule

// File: rtl/decode_stage.sv
// Fetch->execute decode stage: one registered micro-op per instruction, with a small FSM
// that reassembles the 3-word LOADI64 form. Optional DECODE_STATS_EN adds op/illegal counters.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [7:0] MAX_OPCODE = DEF_MAX_OPCODE,
  parameter logic [7:0] LOADI64_OP = LOADI64_OPCODE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic [31:0]       fetch_insn,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [7:0]        dec_opcode,
  output logic [4:0]        dec_rd,
  output logic [4:0]        dec_rs1,
  output logic [4:0]        dec_rs2,
  output logic [63:0]       dec_imm,
  output logic              dec_illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]       stat_ops,
  output logic [31:0]       stat_illegal
`endif
);

  decode_state_e state_q, state_d;
  DecodedOp      fld;
  DecodedOp      out_q, out_d;
  DecodedOp      pend_q, pend_d;
  logic [31:0]   imm_lo_q, imm_lo_d;
  logic          dec_valid_q, dec_valid_d;
  logic          out_free;
  logic          accept;
  logic          load_out;

  decode_fields #(
    .MAX_OPCODE (MAX_OPCODE)
  ) u_fields (
    .pc   (fetch_pc),
    .insn (fetch_insn),
    .op   (fld)
  );

  assign out_free = !dec_valid_q || dec_ready;
  // IMM_LO never touches the output register, so it is the only state that ignores back-pressure.
  assign fetch_ready = !flush && (out_free || (state_q == StImmLo));
  assign accept      = fetch_valid && fetch_ready;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    imm_lo_d = imm_lo_q;
    out_d    = out_q;
    load_out = 1'b0;

    if (accept) begin
      unique case (state_q)
        StDecode: begin
          if (fld.opcode == LOADI64_OP) begin
            pend_d  = fld;
            state_d = StImmLo;
          end else begin
            out_d    = fld;
            load_out = 1'b1;
          end
        end
        StImmLo: begin
          imm_lo_d = fetch_insn;
          state_d  = StImmHi;
        end
        StImmHi: begin
          out_d     = pend_q;
          out_d.imm = {fetch_insn, imm_lo_q};
          load_out  = 1'b1;
          state_d   = StDecode;
        end
        default: state_d = StDecode;
      endcase
    end

    if (flush) begin
      state_d = StDecode;
    end

    if (flush) begin
      dec_valid_d = 1'b0;
    end else if (load_out) begin
      dec_valid_d = 1'b1;
    end else if (dec_ready) begin
      dec_valid_d = 1'b0;
    end else begin
      dec_valid_d = dec_valid_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StDecode;
      out_q       <= '0;
      pend_q      <= '0;
      imm_lo_q    <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      pend_q      <= pend_d;
      imm_lo_q    <= imm_lo_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign dec_valid   = dec_valid_q;
  assign dec_pc      = out_q.pc;
  assign dec_opcode  = out_q.opcode;
  assign dec_rd      = out_q.rd;
  assign dec_rs1     = out_q.rs1;
  assign dec_rs2     = out_q.rs2;
  assign dec_imm     = out_q.imm;
  assign dec_illegal = out_q.illegal;

`ifdef DECODE_STATS_EN
  logic [31:0] stat_ops_q;
  logic [31:0] stat_illegal_q;

  // Counts delivered ops only; flush does not clear the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops_q     <= '0;
      stat_illegal_q <= '0;
    end else if (dec_valid_q && dec_ready) begin
      stat_ops_q <= stat_ops_q + 32'd1;
      if (out_q.illegal) begin
        stat_illegal_q <= stat_illegal_q + 32'd1;
      end
    end
  end

  assign stat_ops     = stat_ops_q;
  assign stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push expected ops, a forked monitor
// pops and compares on every delivered op. Stats checks compile in with DECODE_STATS_EN.
module tb_decode_stage;
  import decode_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              flush = 1'b0;
  logic              fetch_valid = 1'b0;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_pc = '0;
  logic [31:0]       fetch_insn = '0;
  logic              dec_valid;
  logic              dec_ready = 1'b1;
  logic [ADDR_W-1:0] dec_pc;
  logic [7:0]        dec_opcode;
  logic [4:0]        dec_rd;
  logic [4:0]        dec_rs1;
  logic [4:0]        dec_rs2;
  logic [63:0]       dec_imm;
  logic              dec_illegal;
`ifdef DECODE_STATS_EN
  logic [31:0]       stat_ops;
  logic [31:0]       stat_illegal;
`endif

  int       n_cmp = 0;
  int       n_err = 0;
  DecodedOp exp_q[$];
  DecodedOp act;
  DecodedOp exp_op;

  decode_stage dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .fetch_insn  (fetch_insn),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .dec_opcode  (dec_opcode),
    .dec_rd      (dec_rd),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_imm     (dec_imm),
    .dec_illegal (dec_illegal)
`ifdef DECODE_STATS_EN
    ,
    .stat_ops    (stat_ops),
    .stat_illegal(stat_illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] actual, logic [63:0] required);
    n_cmp++;
    if (actual !== required) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic expect_op(logic [63:0] pc, logic [7:0] opc, logic [4:0] rd, logic [4:0] rs1,
                           logic [4:0] rs2, logic [63:0] imm, logic ill);
    DecodedOp e;
    e.pc      = pc;
    e.opcode  = opc;
    e.rd      = rd;
    e.rs1     = rs1;
    e.rs2     = rs2;
    e.imm     = imm;
    e.illegal = ill;
    exp_q.push_back(e);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the word.
  task automatic send(logic [63:0] pc, logic [31:0] insn);
    int n = 0;
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_insn  = insn;
    @(negedge clk);
    while (!fetch_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!fetch_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout pc=%h: fetch_ready stayed 0, required 1", pc);
    end else begin
      @(posedge clk);
    end
    #1;
    fetch_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_dec_valid", dec_valid, 0);
    check("rst_dec_pc", dec_pc, 0);
    check("rst_dec_opcode", dec_opcode, 0);
    check("rst_dec_regs", {dec_rd, dec_rs1, dec_rs2}, 0);
    check("rst_dec_imm", dec_imm, 0);
    check("rst_dec_illegal", dec_illegal, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_fetch_ready", fetch_ready, 1);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (reset_n && dec_valid && dec_ready) begin
          act.pc      = dec_pc;
          act.opcode  = dec_opcode;
          act.rd      = dec_rd;
          act.rs1     = dec_rs1;
          act.rs2     = dec_rs2;
          act.imm     = dec_imm;
          act.illegal = dec_illegal;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_op: got %h, required no op", act);
          end else begin
            exp_op = exp_q.pop_front();
            if (act !== exp_op) begin
              n_err++;
              $display("FAIL op_pc_%0h: got %h, required %h", exp_op.pc, act, exp_op);
            end
          end
        end
      end
    join_none

    #1;
    do_reset();

    // Plain decode, latency 1.
    expect_op(64'h100, 8'h0A, 5'h11, 5'h08, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'h100, 32'h0A8A_3FFF);
    check("t1_latency_valid", dec_valid, 1);

    // LOADI64 reassembly.
    expect_op(64'h200, 8'h3F, 5'h02, 5'h00, 5'h00, 64'h0123_4567_DEAD_BEEF, 1'b0);
    send(64'h200, 32'h3F10_0000);
    check("t2_valid_after_op", dec_valid, 0);
    send(64'h204, 32'hDEAD_BEEF);
    check("t2_valid_after_lo", dec_valid, 0);
    send(64'h208, 32'h0123_4567);
    check("t2_valid_after_hi", dec_valid, 1);
    @(posedge clk);
    #1;

    // Back-pressure: one accept, then stall with held outputs.
    dec_ready = 1'b0;
    expect_op(64'h300, 8'h05, 5'h01, 5'h01, 5'h01, 64'h205, 1'b0);
    expect_op(64'h304, 8'h06, 5'h1F, 5'h1F, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    expect_op(64'h308, 8'h07, 5'h00, 5'h00, 5'h10, 64'hFFFF_FFFF_FFFF_E000, 1'b0);
    send(64'h300, 32'h0508_4205);
    fetch_valid = 1'b1;
    fetch_pc    = 64'h304;
    fetch_insn  = 32'h06FF_FFFE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_stall_fetch_ready", fetch_ready, 0);
      check("t3_stall_dec_pc", dec_pc, 64'h300);
      check("t3_stall_dec_imm", dec_imm, 64'h205);
    end
    @(posedge clk);
    #1;
    dec_ready = 1'b1;
    send(64'h304, 32'h06FF_FFFE);
    send(64'h308, 32'h0700_2000);

    // Flush while waiting for the high immediate word.
    send(64'h400, 32'h3F00_0000);
    send(64'h404, 32'h1111_1111);
    fetch_valid = 1'b1;
    fetch_pc    = 64'h408;
    fetch_insn  = 32'h2222_2222;
    flush       = 1'b1;
    @(negedge clk);
    check("t4_flush_fetch_ready", fetch_ready, 0);
    @(posedge clk);
    #1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    check("t4_flush_dec_valid", dec_valid, 0);
    expect_op(64'h500, 8'h0A, 5'h11, 5'h08, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'h500, 32'h0A8A_3FFF);

    // Illegal opcode still delivered.
    expect_op(64'h600, 8'h40, 5'h00, 5'h00, 5'h00, 64'h5, 1'b1);
    send(64'h600, 32'h4000_0005);
    @(posedge clk);
    #1;

    // Reset with an undelivered op held, then reset mid-LOADI64.
    dec_ready = 1'b0;
    send(64'h680, 32'h0A8A_3FFF);
    check("t5_held_before_reset", dec_valid, 1);
    do_reset();
    dec_ready = 1'b1;
    send(64'h700, 32'h3F00_0000);
    send(64'h704, 32'h5555_5555);
    do_reset();
    expect_op(64'h800, 8'h0A, 5'h11, 5'h08, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'h800, 32'h0A8A_3FFF);

    // Four more ops (one illegal), then an op flushed before delivery.
    expect_op(64'h804, 8'h05, 5'h01, 5'h01, 5'h01, 64'h205, 1'b0);
    expect_op(64'h808, 8'h06, 5'h1F, 5'h1F, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    expect_op(64'h80C, 8'h07, 5'h00, 5'h00, 5'h10, 64'hFFFF_FFFF_FFFF_E000, 1'b0);
    expect_op(64'h810, 8'hFF, 5'h00, 5'h00, 5'h00, 64'h1, 1'b1);
    send(64'h804, 32'h0508_4205);
    send(64'h808, 32'h06FF_FFFE);
    send(64'h80C, 32'h0700_2000);
    send(64'h810, 32'hFF00_0001);
    @(posedge clk);
    #1;
    dec_ready = 1'b0;
    send(64'h900, 32'h0A8A_3FFF);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("t6_flushed_op_dropped", dec_valid, 0);
    dec_ready = 1'b1;
`ifdef DECODE_STATS_EN
    check("t6_stat_ops", stat_ops, 5);
    check("t6_stat_illegal", stat_illegal, 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
